spectrum_peak_scan: RTL and testbench

- Scan controller directly upstream of the amplitude unit.
- Walks the DFT bin buffer and hands each (re, im) pair to the amplitude unit with its start/done handshake.
- Writes each returned magnitude into the magnitude RAM and tracks the largest magnitude and its bin index.
- Sits between the DFT accumulator's bin buffer and the display/peak readout logic.

---
 rtl/spectrum_peak_scan.sv | 122 ++++++++++++
 tb/tb_spectrum_peak_scan.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_peak_scan.sv
// spectrum_peak_scan: walks the DFT bin buffer through the amplitude unit,
// writes each magnitude to the magnitude RAM and tracks the peak bin.
module spectrum_peak_scan #(
   parameter int ADDR_W = 8,
   parameter int N_BINS = 256,
   parameter bit SKIP_DC = 1,
   parameter int TIMEOUT = 1023
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic done,
   output logic err,
   output logic [ADDR_W-1:0] bin_addr,
   input  logic [31:0] bin_re,
   input  logic [31:0] bin_im,
   output logic amp_start,
   output logic [31:0] amp_x,
   output logic [31:0] amp_y,
   input  logic [31:0] amp_ampli,
   input  logic amp_done,
   output logic mag_we,
   output logic [ADDR_W-1:0] mag_addr,
   output logic [31:0] mag_data,
   output logic [31:0] peak_val,
   output logic [ADDR_W-1:0] peak_idx,
   output logic peak_valid
);
   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_BINS - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
   typedef enum logic [3:0] {IDLE, RD, LAT, KICK, WFALL, WRISE, STORE, NEXT, FIN, ABORT} state_t;
   state_t state;
   logic [ADDR_W-1:0] bin;
   logic [TO_W-1:0] cnt;
   logic qualify, better;
   assign bin_addr = bin;
   assign mag_addr = bin;
   // Inf/NaN never qualify; magnitude compare ignores the sign bit
   always_comb begin
      qualify = (mag_data[30:23] != 8'hFF) && !(SKIP_DC && bin == '0);
      better = !peak_valid || (mag_data[30:0] > peak_val[30:0]);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         bin <= '0;
         cnt <= '0;
         done <= 1'b1;
         err <= 1'b0;
         amp_start <= 1'b0;
         amp_x <= '0;
         amp_y <= '0;
         mag_we <= 1'b0;
         mag_data <= '0;
         peak_val <= '0;
         peak_idx <= '0;
         peak_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               err <= 1'b0;
               peak_val <= '0;
               peak_idx <= '0;
               peak_valid <= 1'b0;
               bin <= '0;
               done <= 1'b0;
               state <= RD;
            end
            RD: state <= LAT;
            LAT: begin
               amp_x <= bin_re;
               amp_y <= bin_im;
               amp_start <= 1'b1;
               state <= KICK;
            end
            KICK: begin
               amp_start <= 1'b0;
               cnt <= '0;
               state <= WFALL;
            end
            WFALL: if (!amp_done) begin
               cnt <= '0;
               state <= WRISE;
            end else if (cnt == TO_LAST) begin
               err <= 1'b1;
               done <= 1'b1;
               state <= ABORT;
            end else cnt <= cnt + 1'b1;
            WRISE: if (amp_done) begin
               mag_data <= amp_ampli;
               mag_we <= 1'b1;
               state <= STORE;
            end else if (cnt == TO_LAST) begin
               err <= 1'b1;
               done <= 1'b1;
               state <= ABORT;
            end else cnt <= cnt + 1'b1;
            STORE: begin
               mag_we <= 1'b0;
               if (qualify && better) begin
                  peak_val <= mag_data;
                  peak_idx <= bin;
                  peak_valid <= 1'b1;
               end
               state <= NEXT;
            end
            NEXT: if (bin == LAST) state <= FIN;
            else begin
               bin <= bin + 1'b1;
               state <= RD;
            end
            FIN: begin
               done <= 1'b1;
               state <= IDLE;
            end
            ABORT: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spectrum_peak_scan.sv
// tb_spectrum_peak_scan: directed vectors against two scan instances,
// unit 0 plain (SKIP_DC=0) and unit 1 skip-DC with a 15-cycle timeout.
module tb_spectrum_peak_scan;
   typedef struct {
      int g;
      bit raw;
      logic [7:0][31:0] re;
      logic [7:0][31:0] im;
      logic [31:0] pv;
      logic [7:0] pi;
      int ca;
      logic [31:0] cm;
   } vec_t;
   logic clk = 0, reset = 1;
   logic [1:0] start = 2'b00, done, err, amp_start, mag_we, peak_valid;
   logic [1:0] amp_done = 2'b11, busy = 2'b00, done_q = 2'b11;
   logic [7:0] bin_addr [2], mag_addr [2], peak_idx [2];
   logic [31:0] bin_re [2], bin_im [2], amp_x [2], amp_y [2], amp_ampli [2], mag_data [2], peak_val [2];
   logic [31:0] re_mem [2][8], im_mem [2][8], mag_ram [2][8];
   int we_tot [2], rises [2], acnt [2][8], cnt [2];
   int rise [2] = '{20, 8};
   bit raw = 0, stuck = 0;
   int total = 0, bad = 0;
   vec_t v [8];
   always #5 clk = ~clk;
   for (genvar g = 0; g < 2; g++) begin : g_u
      spectrum_peak_scan #(.ADDR_W(8), .N_BINS(8), .SKIP_DC(g == 1), .TIMEOUT(g == 1 ? 15 : 1023)) dut (
         .clk(clk), .reset(reset), .start(start[g]), .done(done[g]), .err(err[g]),
         .bin_addr(bin_addr[g]), .bin_re(bin_re[g]), .bin_im(bin_im[g]),
         .amp_start(amp_start[g]), .amp_x(amp_x[g]), .amp_y(amp_y[g]),
         .amp_ampli(amp_ampli[g]), .amp_done(amp_done[g]),
         .mag_we(mag_we[g]), .mag_addr(mag_addr[g]), .mag_data(mag_data[g]),
         .peak_val(peak_val[g]), .peak_idx(peak_idx[g]), .peak_valid(peak_valid[g]));
   end
   function automatic real from_sp(input logic [31:0] s);
      if (s[30:0] == 0) return 0.0;
      return $bitstoreal({s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0});
   endfunction
   function automatic logic [31:0] to_sp(input real r);
      logic [63:0] d;
      d = $realtobits(r);
      if (r == 0.0) return 32'd0;
      return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
   endfunction
   // bin buffer with 1-cycle read latency and a behavioural amplitude unit
   always @(posedge clk) for (int g = 0; g < 2; g++) begin
      bin_re[g] <= re_mem[g][bin_addr[g][2:0]];
      bin_im[g] <= im_mem[g][bin_addr[g][2:0]];
      if (amp_start[g] && !stuck) begin
         busy[g] <= 1'b1;
         cnt[g] <= 0;
         amp_ampli[g] <= raw ? amp_x[g] :
            to_sp($sqrt(from_sp(amp_x[g]) * from_sp(amp_x[g]) + from_sp(amp_y[g]) * from_sp(amp_y[g])));
      end else if (busy[g]) begin
         cnt[g] <= cnt[g] + 1;
         if (cnt[g] == 1) amp_done[g] <= 1'b0;
         if (cnt[g] == 1 + rise[g]) begin
            amp_done[g] <= 1'b1;
            busy[g] <= 1'b0;
         end
      end
   end
   always @(negedge clk) for (int g = 0; g < 2; g++) begin
      if (mag_we[g]) begin
         we_tot[g] <= we_tot[g] + 1;
         acnt[g][mag_addr[g][2:0]] <= acnt[g][mag_addr[g][2:0]] + 1;
         mag_ram[g][mag_addr[g][2:0]] <= mag_data[g];
      end
      if (done[g] && !done_q[g]) rises[g] <= rises[g] + 1;
      done_q[g] <= done[g];
   end
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%h want=%h", n, a, e);
      end
   endtask
   task automatic pulse(input int g);
      start[g] = 1'b1;
      @(negedge clk);
      start[g] = 1'b0;
   endtask
   task automatic wait_done(input int g);
      for (int k = 0; k < 4000 && !done[g]; k++) @(negedge clk);
      chk("done_seen", 32'(done[g]), 1);
      @(negedge clk);
   endtask
   task automatic scan_checks(input int g, input int we0, input int rs0, input int a0 [8]);
      logic [7:0] m;
      for (int b = 0; b < 8; b++) m[b] = (acnt[g][b] - a0[b]) == 1;
      chk("mag_we_count", we_tot[g] - we0, 8);
      chk("done_rises", rises[g] - rs0, 1);
      chk("mag_addrs", 32'(m), 32'hFF);
      chk("err_clear", 32'(err[g]), 0);
   endtask
   task automatic setv(input int i, input int g, input bit r, input logic [31:0] pv, input logic [7:0] pi,
                       input int ca, input logic [31:0] cm);
      v[i].g = g;
      v[i].raw = r;
      v[i].re = '0;
      v[i].im = '0;
      v[i].pv = pv;
      v[i].pi = pi;
      v[i].ca = ca;
      v[i].cm = cm;
   endtask
   task automatic load(input int i);
      for (int b = 0; b < 8; b++) begin
         re_mem[v[i].g][b] = v[i].re[b];
         im_mem[v[i].g][b] = v[i].im[b];
      end
      raw = v[i].raw;
   endtask
   initial begin
      int g, we0, rs0, k;
      int a0 [8];
      setv(0, 0, 0, 32'h40A00000, 5, 5, 32'h40A00000);
      v[0].re[5] = 32'h40400000;
      v[0].im[5] = 32'h40800000;
      setv(1, 0, 0, 32'h40000000, 2, 6, 32'h40000000);
      v[1].re[2] = 32'h40000000;
      v[1].re[6] = 32'h40000000;
      setv(2, 1, 0, 32'h3F800000, 3, 0, 32'h42C80000);
      v[2].re[0] = 32'h42C80000;
      v[2].re[3] = 32'h3F800000;
      setv(3, 0, 1, 32'h40000000, 1, 4, 32'h7FC00000);
      v[3].re[4] = 32'h7FC00000;
      v[3].re[1] = 32'h40000000;
      setv(4, 0, 1, 32'hC0800000, 3, 6, 32'h40400000);
      v[4].re[3] = 32'hC0800000;
      v[4].re[6] = 32'h40400000;
      setv(5, 0, 0, 32'h0, 0, 7, 32'h0);
      setv(6, 1, 0, 32'h0, 1, 0, 32'h0);
      setv(7, 1, 1, 32'h3F800000, 2, 5, 32'h7F800000);
      v[7].re[5] = 32'h7F800000;
      v[7].re[2] = 32'h3F800000;
      repeat (3) @(negedge clk);
      chk("rst_done", 32'(done), 32'h3);
      chk("rst_err", 32'(err), 0);
      chk("rst_peak_valid", 32'(peak_valid), 0);
      chk("rst_peak_val", peak_val[0], 0);
      chk("rst_bin_addr", 32'(bin_addr[0]), 0);
      chk("rst_strobes", 32'({amp_start, mag_we}), 0);
      reset = 0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         g = v[i].g;
         load(i);
         we0 = we_tot[g];
         rs0 = rises[g];
         a0 = acnt[g];
         pulse(g);
         wait_done(g);
         scan_checks(g, we0, rs0, a0);
         chk("peak_val", peak_val[g], v[i].pv);
         chk("peak_idx", 32'(peak_idx[g]), 32'(v[i].pi));
         chk("peak_valid", 32'(peak_valid[g]), 1);
         chk("mag_ram", mag_ram[g][v[i].ca], v[i].cm);
      end
      // stuck amplitude unit: abort after 15 WFALL cycles, then recover
      load(6);
      stuck = 1;
      we0 = we_tot[1];
      pulse(1);
      for (k = 0; k < 10 && !amp_start[1]; k++) @(negedge clk);
      chk("kick_seen", 32'(amp_start[1]), 1);
      for (k = 0; k < 40 && !done[1]; k++) @(negedge clk);
      chk("abort_cycles", k, 16);
      chk("abort_err", 32'(err[1]), 1);
      @(negedge clk);
      chk("abort_no_we", we_tot[1] - we0, 0);
      chk("abort_peak_valid", 32'(peak_valid[1]), 0);
      stuck = 0;
      we0 = we_tot[1];
      rs0 = rises[1];
      a0 = acnt[1];
      pulse(1);
      chk("err_cleared_on_start", 32'(err[1]), 0);
      wait_done(1);
      scan_checks(1, we0, rs0, a0);
      chk("recover_peak_idx", 32'(peak_idx[1]), 1);
      // start during bin 3 is ignored
      load(0);
      we0 = we_tot[0];
      rs0 = rises[0];
      a0 = acnt[0];
      pulse(0);
      for (k = 0; k < 2000 && bin_addr[0] != 8'd3; k++) @(negedge clk);
      chk("reach_bin3", 32'(bin_addr[0]), 3);
      pulse(0);
      wait_done(0);
      scan_checks(0, we0, rs0, a0);
      chk("ignored_start_idx", 32'(peak_idx[0]), 5);
      // reset during bin 4 WRISE
      we0 = we_tot[0];
      pulse(0);
      for (k = 0; k < 2000 && !(bin_addr[0] == 8'd4 && !amp_done[0]); k++) @(negedge clk);
      chk("reach_bin4_wrise", 32'(bin_addr[0]), 4);
      @(negedge clk);
      reset = 1;
      #1;
      chk("midrst_done", 32'(done[0]), 1);
      chk("midrst_peak_valid", 32'(peak_valid[0]), 0);
      chk("midrst_bin_addr", 32'(bin_addr[0]), 0);
      chk("midrst_peak_val", peak_val[0], 0);
      repeat (2) @(negedge clk);
      reset = 0;
      repeat (40) @(negedge clk);
      chk("midrst_we_count", we_tot[0] - we0, 4);
      we0 = we_tot[0];
      rs0 = rises[0];
      a0 = acnt[0];
      pulse(0);
      wait_done(0);
      scan_checks(0, we0, rs0, a0);
      chk("post_rst_idx", 32'(peak_idx[0]), 5);
      chk("post_rst_val", peak_val[0], 32'h40A00000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
